// File: rtl/program_loader.sv
// Framed byte-stream loader: parses HEADER, N, N*3 payload bytes and an XOR checksum,
// writing each assembled command word into the program array while holding the core idle.
module program_loader #(
    parameter int         CLK_FREQUENCY    = 100_000_000,
    parameter int         MAX_NUM_COMMANDS = 64,
    parameter int         ADDR_W           = $clog2(MAX_NUM_COMMANDS),
    parameter int         CMD_W            = 24,
    parameter int         TIMEOUT_CYCLES   = CLK_FREQUENCY / 10,
    parameter logic [7:0] HEADER_BYTE      = 8'hA5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_valid_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [CMD_W-1:0]  wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [7:0]        cmd_count_out
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_N    = 8'(MAX_NUM_COMMANDS);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        PAYLOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        acc;
    logic [7:0]        cmd_n;
    logic [7:0]        word_idx;
    logic [1:0]        byte_idx;
    logic [15:0]       asm_word;
    logic [TMR_W-1:0]  tmr;

    logic hdr_seen;
    logic timed;
    logic timeout_hit;
    logic last_byte;
    logic last_word;
    logic start;

    assign hdr_seen    = rx_valid_in && (rx_data_in == HEADER_BYTE);
    assign timed       = (state == COUNT) || (state == PAYLOAD) || (state == CHECK);
    assign timeout_hit = timed && !rx_valid_in && (tmr == TMR_LAST);
    assign last_byte   = (byte_idx == 2'd2);
    assign last_word   = (word_idx == cmd_n - 8'd1);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE also accepts a header so a frame sent right behind a good one is not lost.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        err_out   = 1'b0;
        case (state)
            IDLE: begin
                if (hdr_seen) begin
                    start     = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                busy_out = 1'b1;
                if (timeout_hit) begin
                    state_nxt = ERR;
                end else if (rx_valid_in) begin
                    if (rx_data_in > MAX_N)       state_nxt = ERR;
                    else if (rx_data_in == 8'd0)  state_nxt = CHECK;
                    else                          state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                busy_out = 1'b1;
                if (timeout_hit)
                    state_nxt = ERR;
                else if (rx_valid_in && last_byte && last_word)
                    state_nxt = CHECK;
            end
            CHECK: begin
                busy_out = 1'b1;
                if (timeout_hit)
                    state_nxt = ERR;
                else if (rx_valid_in)
                    state_nxt = (rx_data_in == acc) ? DONE : ERR;
            end
            DONE: begin
                done_out = 1'b1;
                if (hdr_seen) begin
                    start     = 1'b1;
                    state_nxt = COUNT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                busy_out = 1'b1;
                err_out  = 1'b1;
                if (hdr_seen) begin
                    start     = 1'b1;
                    state_nxt = COUNT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Inter-byte gap timer; saturates so it never wraps while waiting for the FSM to leave.
    always_ff @(posedge clk_in) begin
        if (rst_in || !timed || rx_valid_in)
            tmr <= '0;
        else if (tmr != TMR_LAST)
            tmr <= tmr + TMR_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc           <= '0;
            cmd_n         <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            asm_word      <= '0;
            wr_en_out     <= 1'b0;
            wr_addr_out   <= '0;
            wr_data_out   <= '0;
            cmd_count_out <= '0;
        end else begin
            wr_en_out <= 1'b0;
            if (start) begin
                acc      <= '0;
                cmd_n    <= '0;
                word_idx <= '0;
                byte_idx <= '0;
            end
            case (state)
                COUNT: begin
                    if (rx_valid_in) begin
                        acc   <= acc ^ rx_data_in;
                        cmd_n <= rx_data_in;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid_in) begin
                        acc <= acc ^ rx_data_in;
                        if (last_byte) begin
                            wr_en_out   <= 1'b1;
                            wr_addr_out <= word_idx[ADDR_W-1:0];
                            wr_data_out <= CMD_W'({asm_word, rx_data_in});
                            word_idx    <= word_idx + 8'd1;
                            byte_idx    <= 2'd0;
                        end else begin
                            asm_word <= {asm_word[7:0], rx_data_in};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                CHECK: begin
                    if (rx_valid_in && rx_data_in == acc)
                        cmd_count_out <= cmd_n;
                end
                default: ;
            endcase
        end
    end

endmodule
